fetch_unit: RTL and testbench

- Decoupled instruction-fetch stage directly upstream of fetch_decode.
- Generates sequential word-aligned fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small prefetch queue and presents {instr, instr_pc} to decode with a valid/ready handshake.
- On a branch/jump redirect, flushes the queue and discards stale in-flight responses, replacing the free-running PC register of the unpipelined core.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Handshake bundle between fetch_unit, instruction memory, execute (redirect) and decode.
// The master modport is the fetch unit's view.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, instr_fault,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, instr_fault,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: sequential word fetch with credit-limited issue, in-order
// prefetch queue toward decode, and redirect flush that drops stale in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_unit_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]             fetch_pc_q, fetch_pc_d;
    logic [31:0]             resp_pc_q, resp_pc_d;
    logic [CW-1:0]           outst_q, outst_d;
    logic [CW-1:0]           drop_q, drop_d;
    logic [CW-1:0]           count_q, count_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0][31:0]  data_q, data_d;
    logic [DEPTH-1:0][31:0]  pc_q, pc_d;

    logic          req_fire, resp_fire, push, pop;
    logic [CW:0]   credit_used;
    logic [31:0]   target_pc;

    always_comb begin
        credit_used = {1'b0, outst_q} + {1'b0, count_q};
        target_pc   = bus.redirect_pc & ~32'h3;

        bus.imem_req_valid = reset_n && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
        bus.imem_addr      = fetch_pc_q;
        bus.instr_valid    = (count_q != '0) && !bus.redirect_valid;
        bus.instr          = data_q[rd_ptr_q];
        bus.instr_pc       = pc_q[rd_ptr_q];
        bus.instr_fault    = (data_q[rd_ptr_q] == 32'hbadbadff);

        req_fire  = bus.imem_req_valid && bus.imem_req_ready;
        resp_fire = bus.imem_resp_valid;
        pop       = bus.instr_valid && bus.instr_ready;
        push      = resp_fire && (drop_q == '0) && !bus.redirect_valid;

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        data_d     = data_q;
        pc_d       = pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(resp_fire);

        if (bus.redirect_valid) begin
            // Everything still in flight (including earlier pending drops) belongs to the old stream.
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            drop_d     = outst_q - CW'(resp_fire);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp_fire && (drop_q != '0))
                drop_d = drop_q - 1'b1;
            // Surviving responses are the current stream in order, so their pc is a running counter.
            if (push) begin
                data_d[wr_ptr_q] = bus.imem_resp_data;
                pc_d[wr_ptr_q]   = resp_pc_q;
                wr_ptr_d         = wr_ptr_q + 1'b1;
                resp_pc_d        = resp_pc_q + 32'd4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            data_q     <= '0;
            pc_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency, stream-level reference
// (expected request and delivery pc per stream), directed scenarios plus a random phase.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0100_0000;
    localparam int          DEPTH  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.master)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0100_0408 || (a[9:2] % 8'd23) == 8'd5) return 32'hbadbadff;
        return (a * 32'h9e37_79b1) ^ 32'h0f0f_1234;
    endfunction

    // Instruction memory: in-order, latency >= 1 cycle after acceptance
    typedef struct { logic [31:0] a; int due; } mreq_t;
    mreq_t mq[$];
    bit rdy_rand = 0, lat_rand = 0;
    int lat_fix = 1;

    initial begin
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                mq.delete();
                bus.imem_resp_valid = 1'b0;
                bus.imem_req_ready  = 1'b1;
            end else begin
                bus.imem_req_ready  = rdy_rand ? ($urandom % 4 != 0) : 1'b1;
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = $urandom;
                if (mq.size() > 0 && mq[0].due <= cyc && (!lat_rand || $urandom % 3 != 0)) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_word(mq[0].a);
                    void'(mq.pop_front());
                end
            end
        end
    end

    // Reference: each stream starts at its target and advances by 4 per request / per delivery
    logic [31:0] exp_req, exp_pc;
    int out_m = 0, acc_cnt = 0, pop_cnt = 0;
    int first_acc_cyc = -1, first_vld_cyc = -1;
    logic [31:0] acc_log[$], pop_log[$];
    bit fault_log[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
            chk("rst_instr", bus.instr, 32'd0);
            chk("rst_instr_pc", bus.instr_pc, 32'd0);
            chk("rst_fault", 32'(bus.instr_fault), 32'd0);
            exp_req = RST_PC;
            exp_pc  = RST_PC;
            out_m   = 0;
        end else begin
            if (bus.imem_resp_valid) out_m--;
            if (bus.redirect_valid) begin
                chk("redir_no_req", 32'(bus.imem_req_valid), 32'd0);
                chk("redir_no_vld", 32'(bus.instr_valid), 32'd0);
                exp_req = bus.redirect_pc & ~32'h3;
                exp_pc  = bus.redirect_pc & ~32'h3;
            end else begin
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    chk("req_addr", bus.imem_addr, exp_req);
                    mq.push_back('{bus.imem_addr, cyc + (lat_rand ? 1 + int'($urandom % 3) : lat_fix)});
                    acc_log.push_back(bus.imem_addr);
                    acc_cnt++;
                    out_m++;
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    exp_req = exp_req + 32'd4;
                end
                if (bus.instr_valid) begin
                    chk("instr_pc", bus.instr_pc, exp_pc);
                    chk("instr", bus.instr, mem_word(exp_pc));
                    chk("instr_fault", 32'(bus.instr_fault), 32'(mem_word(exp_pc) == 32'hbadbadff));
                    if (first_vld_cyc < 0) first_vld_cyc = cyc;
                    if (bus.instr_ready) begin
                        pop_log.push_back(bus.instr_pc);
                        fault_log.push_back(bus.instr_fault);
                        pop_cnt++;
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end
            chk("outstanding_bound", 32'(out_m <= DEPTH), 32'd1);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete(); pop_log.delete(); fault_log.delete();
        acc_cnt = 0; pop_cnt = 0; first_acc_cyc = -1; first_vld_cyc = -1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [31:0] exp, input bit use_pop);
        logic [31:0] v;
        v = 32'hdead_0000;
        if (use_pop && pop_log.size() > idx) v = pop_log[idx];
        if (!use_pop && acc_log.size() > idx) v = acc_log[idx];
        chk(nm, v, exp);
    endtask

    initial begin
        bit hit;
        logic [31:0] r;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b1;

        // Streaming with 1-cycle memory
        do_reset();
        tick(30);
        chk_log("t1_first_pc", 0, RST_PC, 1);
        chk_log("t1_acc1", 1, 32'h0100_0004, 0);
        chk("t1_latency", 32'(first_vld_cyc - first_acc_cyc), 32'd2);
        chk("t1_sustain", 32'(pop_cnt >= 25), 32'd1);

        // Decode stalled: credits cap at DEPTH
        bus.instr_ready = 1'b0;
        do_reset();
        tick(15);
        chk("t2_acc_cnt", 32'(acc_cnt), 32'd4);
        chk("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t2_head_pc", bus.instr_pc, RST_PC);
        bus.instr_ready = 1'b1;
        tick(15);
        for (int i = 0; i < 4; i++) chk_log("t2_drain", i, RST_PC + 32'(4 * i), 1);
        chk_log("t2_resume", 4, 32'h0100_0010, 0);

        // Redirect with 3 outstanding and 1 buffered
        lat_fix = 4;
        bus.instr_ready = 1'b0;
        do_reset();
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (out_m == 3 && bus.instr_valid) hit = 1;
            else tick();
        end
        chk("t3_setup", 32'(hit), 32'd1);
        clear_logs();
        redirect(32'h0100_0103);
        bus.instr_ready = 1'b1;
        tick(25);
        chk_log("t3_first_req", 0, 32'h0100_0100, 0);
        chk_log("t3_first_pop", 0, 32'h0100_0100, 1);

        // Back-to-back redirects: last wins
        lat_fix = 2;
        do_reset();
        tick(6);
        redirect(32'h0100_0200);
        clear_logs();
        redirect(32'h0100_0300);
        tick(20);
        chk_log("t4_first_req", 0, 32'h0100_0300, 0);
        chk_log("t4_first_pop", 0, 32'h0100_0300, 1);

        // Fault marker on exactly one entry
        lat_fix = 1;
        clear_logs();
        redirect(32'h0100_0400);
        tick(15);
        chk_log("t5_pc", 2, 32'h0100_0408, 1);
        chk("t5_fault_prev", 32'(fault_log.size() > 1 && fault_log[1]), 32'd0);
        chk("t5_fault_hit", 32'(fault_log.size() > 2 && fault_log[2]), 32'd1);
        chk("t5_fault_next", 32'(fault_log.size() > 3 && fault_log[3]), 32'd0);

        // Async reset with a full queue
        bus.instr_ready = 1'b0;
        do_reset();
        tick(12);
        chk("t6_full_valid", 32'(bus.instr_valid), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_async_vld", 32'(bus.instr_valid), 32'd0);
        chk("t6_async_req", 32'(bus.imem_req_valid), 32'd0);
        tick(2);
        reset_n = 1'b1;
        clear_logs();
        bus.instr_ready = 1'b1;
        tick(10);
        chk_log("t6_restart_req", 0, RST_PC, 0);
        chk_log("t6_restart_pop", 0, RST_PC, 1);

        // Random traffic, redirects and stalls
        rdy_rand = 1;
        lat_rand = 1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.instr_ready = ($urandom % 4 != 0);
            r = $urandom;
            if ($urandom % 25 == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = (r[3:0] == 4'd0) ? {28'hfffffff, r[7:4]} : {RST_PC[31:12], r[11:0]};
            end else begin
                bus.redirect_valid = 1'b0;
            end
            tick();
        end
        bus.redirect_valid = 1'b0;
        tick(20);
        chk("rand_progress", 32'(pop_cnt > 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
